// File: rtl/instr_encoder.sv
// instr_encoder: turns an operation request into an RV32 instruction word.
// Each word is buffered in a 2-entry FIFO and tagged with a running byte address.
//
// Illegal requests produce a NOP with out_err set, and they bump a
// saturating error counter.
//
// Build option: define INSTR_ENCODER_MUL_EN to encode MUL. Without it,
// in_op=4 is treated as illegal.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous flush of FIFO, address and err_cnt
//   in_valid/in_ready     request handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm   request fields
//   out_valid/out_ready   result handshake
//   out_instr, out_addr   encoded word and its byte address
//   out_err, err_cnt      substitution flag and saturating substitution count
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  localparam logic [6:0]  OP_R   = 7'b0110011;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_LD  = 7'b0000011;
  localparam logic [6:0]  OP_ST  = 7'b0100011;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        imm12_ok;
  logic        shamt_ok;

  logic [31:0] mem_word [0:1];
  logic        mem_err  [0:1];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        live;
  logic        push;
  logic        pop;

  // A 12-bit signed immediate fits when bits [31:11] are all sign copies.
  assign imm12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign shamt_ok = (in_imm[31:5] == '0);

  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    case (in_op)
      4'd0: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      4'd1: enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
      4'd2: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OP_R};
      4'd3: enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OP_R};
`ifdef INSTR_ENCODER_MUL_EN
      4'd4: enc_word = {7'b0000001, in_rs2, in_rs1, 3'b000, in_rd, OP_R};
`else
      4'd4: enc_err = 1'b1;
`endif
      4'd5: begin
        if (shamt_ok) enc_word = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, OP_IMM};
        else          enc_err  = 1'b1;
      end
      4'd6: begin
        if (imm12_ok) enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_IMM};
        else          enc_err  = 1'b1;
      end
      4'd7: begin
        if (imm12_ok) enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LD};
        else          enc_err  = 1'b1;
      end
      4'd8: begin
        if (imm12_ok) enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_ST};
        else          enc_err  = 1'b1;
      end
      4'd9:    enc_word = NOP;
      default: enc_err  = 1'b1;
    endcase
  end

  // live holds in_ready low until the first edge after reset release.
  assign in_ready  = live && (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? mem_word[rd_ptr] : 32'h0;
  assign out_err   = out_valid && mem_err[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_word[0] <= '0;
      mem_word[1] <= '0;
      mem_err[0]  <= 1'b0;
      mem_err[1]  <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      live        <= 1'b0;
      out_addr    <= BASE_ADDR;
      err_cnt     <= 8'd0;
    end else begin
      live <= 1'b1;
      if (clr) begin
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
        count    <= 2'd0;
        out_addr <= BASE_ADDR;
        err_cnt  <= 8'd0;
      end else begin
        if (push) begin
          mem_word[wr_ptr] <= enc_word;
          mem_err[wr_ptr]  <= enc_err;
          wr_ptr           <= ~wr_ptr;
          if (enc_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        if (pop) begin
          rd_ptr   <= ~rd_ptr;
          out_addr <= out_addr + 32'd4;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address assigned to the first emitted word after reset or clear.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous flush of buffer, address and error count.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the request handshake.
REQ-006 SHALL have port in_op  input  4  operation select, encoded per REQ-013.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-008 SHALL have port in_imm  input  32  signed immediate; the shift amount for SLLI.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-010 SHALL have port out_instr  output  32  encoded RV32 instruction word.
REQ-011 SHALL have port out_addr  output  32  byte address of out_instr.
REQ-012 SHALL have ports out_err output 1 (current word was substituted) and err_cnt output 8 (saturating count of substitutions).

Function
REQ-013 SHALL use these in_op values: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 SLLI, 6 ADDI, 7 LW, 8 SW, 9 NOP; values 10-15 are illegal.
REQ-014 SHALL encode R-type words with opcode 0110011: ADD f7=0 f3=000; SUB f7=0100000 f3=000; OR f3=110; AND f3=111; MUL f7=0000001 f3=000.
REQ-015 SHALL encode ADDI as opcode 0010011, f3=000, imm[11:0] in bits [31:20].
REQ-016 SHALL encode SLLI as opcode 0010011, f3=001, f7=0, shamt=in_imm[4:0].
REQ-017 SHALL encode LW as opcode 0000011, f3=010, I-type immediate.
REQ-018 SHALL encode SW as opcode 0100011, f3=010, imm[11:5] in bits [31:25] and imm[4:0] in bits [11:7].
REQ-019 SHALL encode NOP as 32'h0000_0013.
REQ-020 SHALL ignore operand fields that the selected format does not use.
REQ-021 SHALL treat a request as illegal when in_op is 10-15, when the immediate lies outside [-2048, 2047] for ADDI/LW/SW, or when the value is outside [0, 31] for SLLI.
REQ-022 SHALL, for an illegal request, emit 32'h0000_0013 with out_err=1 and increment err_cnt, saturating at 255.
REQ-023 SHALL accept a request on a rising edge with in_valid&&in_ready, which captures the encoded word into a 2-entry FIFO.
REQ-024 SHALL present a request accepted at edge N on the outputs after edge N, with 1 cycle latency when the FIFO is empty.
REQ-025 SHALL drive in_ready = (FIFO occupancy < 2), combinationally from registered state only.
REQ-026 SHALL, while full, allow a pop in the same cycle but no push; at occupancy 1 a simultaneous push and pop SHALL keep occupancy at 1.
REQ-027 SHALL hold out_valid high, with out_instr, out_addr and out_err stable, until out_valid&&out_ready.
REQ-028 SHALL advance the address by +4 on each pop, with out_addr = BASE_ADDR + 4*(words popped), wrapping modulo 2^32.
REQ-029 SHALL, on clr, empty the FIFO, reset the address to BASE_ADDR and zero err_cnt, ignoring any concurrent push or pop.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_cnt=0, in_ready=0.
REQ-031 SHALL raise in_ready on the first edge after rst_n deasserts; a reset mid-transfer SHALL discard all buffered words.

Configuration
REQ-032 SHALL, with macro INSTR_ENCODER_MUL_EN defined, encode MUL per REQ-014.
REQ-033 SHALL, without INSTR_ENCODER_MUL_EN, treat in_op=4 as illegal per REQ-022.

Verification
REQ-034 SHALL verify ADD rd=3 rs1=1 rs2=2 -> out_instr 32'h002081B3, out_addr BASE_ADDR, out_err=0.
REQ-035 SHALL verify ADDI rd=5 rs1=0 imm=-1 -> 32'h FFF00293; SW rs1=1 rs2=2 imm=8 -> 32'h0020A423 at address +4.
REQ-036 SHALL verify MUL rd=3 rs1=1 rs2=2 -> 32'h022081B3 with the macro defined; without it -> 32'h00000013, out_err=1, err_cnt=1.
REQ-037 SHALL verify LW imm=2048 and SLLI imm=32 -> both 32'h00000013 with out_err=1, and err_cnt saturating at 255 after 300 illegal requests.
REQ-038 SHALL verify, with out_ready=0 and 3 requests issued: in_ready falls after 2 accepts; after release the words pop in order at +0, +4, +8.
REQ-039 SHALL verify that asserting rst_n=0 or clr with 2 words buffered -> out_valid=0 immediately (rst_n) or next edge (clr), and the next word is emitted at BASE_ADDR.
